// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The requester uses the master modport and the subtractor uses the slave modport.
interface serial_subtractor_if #(
  parameter int unsigned W = 4
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         busy;
  logic         done;

  modport master (
    output start, a, b,
    input  diff, borrow, ovf, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow, ovf, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned/signed subtractor: processes one bit pair per cycle, LSB first.
// The result, borrow and overflow flags are published together with a one-cycle done pulse.
module serial_subtractor #(
  parameter int unsigned W = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  res;
  logic [CW-1:0] count;
  logic          br;
  logic [W-1:0]  diff_q;
  logic          borrow_q;
  logic          ovf_q;
  logic          busy_q;
  logic          done_q;

  logic a_i;
  logic b_i;
  logic d;
  logic br_next;
  logic last_bit;

  // One full-subtractor slice on the current LSBs.
  always_comb begin
    a_i      = a_sh[0];
    b_i      = b_sh[0];
    d        = a_i ^ b_i ^ br;
    br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    last_bit = (count == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // On the last shift the LSB slots hold the original operand MSBs and d is the result MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      count    <= '0;
      br       <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            res   <= '0;
            br    <= 1'b0;
            count <= CW'(W);
          end
        end
        SHIFT: begin
          a_sh  <= {1'b0, a_sh[W-1:1]};
          b_sh  <= {1'b0, b_sh[W-1:1]};
          res   <= {d, res[W-1:1]};
          br    <= br_next;
          count <= count - CW'(1);
          if (last_bit) begin
            diff_q   <= {d, res[W-1:1]};
            borrow_q <= br_next;
            ovf_q    <= (a_i ^ b_i) & (a_i ^ d);
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule
